// File: rtl/program_counter.sv
// program_counter: 8-bit instruction address with increment, absolute jump, relative branch and call/return.
// Define PC_CALL_STACK_EN to build the return-address stack; without it, call is a plain jump and ret holds.
module program_counter #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter int         STACK_DEPTH  = 4
) (
  input  logic       PC_clk,
  input  logic       PC_rst,
  input  logic       PC_stall,
  input  logic       PC_inc_en,
  input  logic       PC_ld_en,
  input  logic [7:0] PC_ld_addr,
  input  logic       PC_br_en,
  input  logic [7:0] PC_br_off,
  input  logic       PC_call_en,
  input  logic       PC_ret_en,
  output logic [7:0] PC_out,
  output logic [3:0] PC_sp,
  output logic       PC_stack_full,
  output logic       PC_stack_empty,
  output logic       PC_err
);

  localparam logic [3:0] SP_MAX = 4'(STACK_DEPTH);

  logic [7:0] pc_q, pc_d;
  logic [7:0] pc_inc;
  logic [7:0] pc_br;

  assign pc_inc = pc_q + 8'd1;
  // An 8-bit modular add is identical to adding the sign-extended offset and truncating.
  assign pc_br  = pc_q + PC_br_off;

`ifdef PC_CALL_STACK_EN
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [3:0]       sp_q, sp_d;
  logic             err_q, err_d;
  logic             push_en;
  logic [7:0]       stack_q [STACK_DEPTH];
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;
  logic             full;
  logic             empty;

  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = IDX_W'(sp_q - 4'd1);
  assign full     = (sp_q == SP_MAX);
  assign empty    = (sp_q == 4'd0);
`endif

  // NOTE: every variable gets its hold value first so no path through the priority chain infers a latch.
  always_comb begin
    pc_d = pc_q;
`ifdef PC_CALL_STACK_EN
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
`endif
    if (!PC_stall) begin
      if (PC_ret_en) begin
`ifdef PC_CALL_STACK_EN
        if (empty) begin
          err_d = 1'b1;
        end else begin
          pc_d = stack_q[pop_idx];
          sp_d = sp_q - 4'd1;
        end
`endif
      end else if (PC_call_en) begin
`ifdef PC_CALL_STACK_EN
        if (full) begin
          err_d = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_d    = sp_q + 4'd1;
          pc_d    = PC_ld_addr;
        end
`else
        pc_d = PC_ld_addr;
`endif
      end else if (PC_ld_en) begin
        pc_d = PC_ld_addr;
      end else if (PC_br_en) begin
        pc_d = pc_br;
      end else if (PC_inc_en) begin
        pc_d = pc_inc;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PC_clk) begin
    if (PC_rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge PC_clk) begin
    if (PC_rst) begin
      sp_q  <= 4'd0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // NOTE: the stack RAM has no reset; entries above PC_sp are never read, so their contents do not matter.
  always_ff @(posedge PC_clk) begin
    if (push_en && !PC_rst) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign PC_sp  = sp_q;
  assign PC_err = err_q;
`else
  assign PC_sp  = 4'd0;
  assign PC_err = 1'b0;
`endif

  assign PC_out         = pc_q;
  assign PC_stack_full  = (PC_sp == SP_MAX);
  assign PC_stack_empty = (PC_sp == 4'd0);

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter; expected outputs are queued at drive time and popped after the edge.
// Covers the stack scenarios when PC_CALL_STACK_EN is defined, and the jump-only behaviour otherwise.
module tb_program_counter;

  typedef struct packed {
    logic       rst;
    logic       stall;
    logic       ret;
    logic       call;
    logic       ld;
    logic       br;
    logic       inc;
    logic [7:0] addr;
    logic [7:0] off;
  } stim_t;

  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] sp;
    logic       full;
    logic       empty;
    logic       err;
  } obs_t;

  logic       PC_clk = 1'b0;
  logic       PC_rst, PC_stall, PC_inc_en, PC_ld_en, PC_br_en, PC_call_en, PC_ret_en;
  logic [7:0] PC_ld_addr, PC_br_off;
  logic [7:0] PC_out;
  logic [3:0] PC_sp;
  logic       PC_stack_full, PC_stack_empty, PC_err;

  int   checks = 0;
  int   errors = 0;
  obs_t sb [$];

  program_counter #(.RESET_VECTOR(8'h00), .STACK_DEPTH(4)) dut (
    .PC_clk        (PC_clk),
    .PC_rst        (PC_rst),
    .PC_stall      (PC_stall),
    .PC_inc_en     (PC_inc_en),
    .PC_ld_en      (PC_ld_en),
    .PC_ld_addr    (PC_ld_addr),
    .PC_br_en      (PC_br_en),
    .PC_br_off     (PC_br_off),
    .PC_call_en    (PC_call_en),
    .PC_ret_en     (PC_ret_en),
    .PC_out        (PC_out),
    .PC_sp         (PC_sp),
    .PC_stack_full (PC_stack_full),
    .PC_stack_empty(PC_stack_empty),
    .PC_err        (PC_err)
  );

  always #5 PC_clk = ~PC_clk;

  function automatic stim_t f_hold();
    return '0;
  endfunction
  function automatic stim_t f_rst();
    stim_t s = '0; s.rst = 1'b1; return s;
  endfunction
  function automatic stim_t f_stall();
    stim_t s = '0; s.stall = 1'b1; return s;
  endfunction
  function automatic stim_t f_inc();
    stim_t s = '0; s.inc = 1'b1; return s;
  endfunction
  function automatic stim_t f_ret();
    stim_t s = '0; s.ret = 1'b1; return s;
  endfunction
  function automatic stim_t f_ld(input logic [7:0] a);
    stim_t s = '0; s.ld = 1'b1; s.addr = a; return s;
  endfunction
  function automatic stim_t f_call(input logic [7:0] a);
    stim_t s = '0; s.call = 1'b1; s.addr = a; return s;
  endfunction
  function automatic stim_t f_br(input logic [7:0] o);
    stim_t s = '0; s.br = 1'b1; s.off = o; return s;
  endfunction

  // Expected observation; full/empty follow from the stack depth of 4.
  function automatic obs_t o(input logic [7:0] pc, input logic [3:0] sp, input logic err);
    obs_t r;
    r.pc = pc;
`ifdef PC_CALL_STACK_EN
    r.sp    = sp;
    r.full  = (sp == 4'd4);
    r.empty = (sp == 4'd0);
    r.err   = err;
`else
    r.sp    = 4'd0;
    r.full  = 1'b0;
    r.empty = 1'b1;
    r.err   = 1'b0;
    if (sp != 4'd0 || err) r.err = 1'bx;
`endif
    return r;
  endfunction

  function automatic obs_t sample();
    return '{pc: PC_out, sp: PC_sp, full: PC_stack_full, empty: PC_stack_empty, err: PC_err};
  endfunction

  task automatic drive(input stim_t s, input obs_t e);
    PC_rst     = s.rst;
    PC_stall   = s.stall;
    PC_ret_en  = s.ret;
    PC_call_en = s.call;
    PC_ld_en   = s.ld;
    PC_br_en   = s.br;
    PC_inc_en  = s.inc;
    PC_ld_addr = s.addr;
    PC_br_off  = s.off;
    sb.push_back(e);
    @(posedge PC_clk);
    #1;
  endtask

  task automatic test_increment();
    stim_t s [7] = '{f_rst(), f_inc(), f_inc(), f_inc(), f_ld(8'hFF), f_inc(), f_hold()};
    obs_t  e [7] = '{o(8'h00,0,0), o(8'h01,0,0), o(8'h02,0,0), o(8'h03,0,0),
                     o(8'hFF,0,0), o(8'h00,0,0), o(8'h00,0,0)};
    obs_t  exp_o, got;
    for (int i = 0; i < 7; i++) begin
      drive(s[i], e[i]);
      exp_o = sb.pop_front();
      got   = sample();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL increment[%0d] got %p expected %p", i, got, exp_o);
      end
    end
  endtask

  task automatic test_branch();
    stim_t s [7] = '{f_ld(8'h10), f_br(8'h05), f_br(8'hF0), f_br(8'h02) | f_inc(),
                     f_ld(8'h02), f_br(8'hFC), f_ld(8'h40) | f_br(8'h01) | f_inc()};
    obs_t  e [7] = '{o(8'h10,0,0), o(8'h15,0,0), o(8'h05,0,0), o(8'h07,0,0),
                     o(8'h02,0,0), o(8'hFE,0,0), o(8'h40,0,0)};
    obs_t  exp_o, got;
    for (int i = 0; i < 7; i++) begin
      drive(s[i], e[i]);
      exp_o = sb.pop_front();
      got   = sample();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL branch[%0d] got %p expected %p", i, got, exp_o);
      end
    end
  endtask

  task automatic test_stall();
    stim_t s [6] = '{f_rst(), f_ld(8'h33),
                     f_stall() | f_inc() | f_ld(8'h99) | f_call(8'h99),
                     f_stall() | f_br(8'h10),
                     f_rst() | f_call(8'h77), f_inc()};
    obs_t  e [6] = '{o(8'h00,0,0), o(8'h33,0,0), o(8'h33,0,0), o(8'h33,0,0),
                     o(8'h00,0,0), o(8'h01,0,0)};
    obs_t  exp_o, got;
    for (int i = 0; i < 6; i++) begin
      drive(s[i], e[i]);
      exp_o = sb.pop_front();
      got   = sample();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL stall[%0d] got %p expected %p", i, got, exp_o);
      end
    end
  endtask

`ifdef PC_CALL_STACK_EN
  task automatic test_call_ret();
    stim_t s [6] = '{f_rst(), f_ld(8'h20), f_call(8'h80), f_call(8'hA0), f_ret(), f_ret()};
    obs_t  e [6] = '{o(8'h00,0,0), o(8'h20,0,0), o(8'h80,1,0), o(8'hA0,2,0),
                     o(8'h81,1,0), o(8'h21,0,0)};
    obs_t  exp_o, got;
    for (int i = 0; i < 6; i++) begin
      drive(s[i], e[i]);
      exp_o = sb.pop_front();
      got   = sample();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL call_ret[%0d] got %p expected %p", i, got, exp_o);
      end
    end
  endtask

  task automatic test_stack_limits();
    stim_t s [15] = '{f_rst(), f_stall() | f_ret(), f_call(8'h10), f_call(8'h20), f_call(8'h30),
                      f_call(8'h40), f_call(8'h50), f_stall() | f_ret(), f_ret(), f_ret(),
                      f_ret(), f_ret(), f_ret(), f_inc(), f_rst()};
    obs_t  e [15] = '{o(8'h00,0,0), o(8'h00,0,0), o(8'h10,1,0), o(8'h20,2,0), o(8'h30,3,0),
                      o(8'h40,4,0), o(8'h40,4,1), o(8'h40,4,1), o(8'h31,3,1), o(8'h21,2,1),
                      o(8'h11,1,1), o(8'h01,0,1), o(8'h01,0,1), o(8'h02,0,1), o(8'h00,0,0)};
    obs_t  exp_o, got;
    for (int i = 0; i < 15; i++) begin
      drive(s[i], e[i]);
      exp_o = sb.pop_front();
      got   = sample();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL stack_limits[%0d] got %p expected %p", i, got, exp_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s [7] = '{f_rst(), f_ld(8'h5A), f_call(8'hC0), f_ret(),
                     f_ret() | f_call(8'h90) | f_inc(), f_rst() | f_call(8'h77), f_ret()};
    obs_t  e [7] = '{o(8'h00,0,0), o(8'h5A,0,0), o(8'hC0,1,0), o(8'h5B,0,0),
                     o(8'h5B,0,1), o(8'h00,0,0), o(8'h00,0,1)};
    obs_t  exp_o, got;
    for (int i = 0; i < 7; i++) begin
      drive(s[i], e[i]);
      exp_o = sb.pop_front();
      got   = sample();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %p expected %p", i, got, exp_o);
      end
    end
  endtask
`else
  task automatic test_no_stack();
    stim_t s [7] = '{f_rst(), f_call(8'h40), f_ret(), f_ret() | f_inc() | f_ld(8'h55),
                     f_inc(), f_stall() | f_call(8'h60), f_call(8'h60) | f_inc()};
    obs_t  e [7] = '{o(8'h00,0,0), o(8'h40,0,0), o(8'h40,0,0), o(8'h40,0,0),
                     o(8'h41,0,0), o(8'h41,0,0), o(8'h60,0,0)};
    obs_t  exp_o, got;
    for (int i = 0; i < 7; i++) begin
      drive(s[i], e[i]);
      exp_o = sb.pop_front();
      got   = sample();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL no_stack[%0d] got %p expected %p", i, got, exp_o);
      end
    end
  endtask
`endif

  initial begin
    PC_rst = 1'b1; PC_stall = 1'b0; PC_inc_en = 1'b0; PC_ld_en = 1'b0; PC_br_en = 1'b0;
    PC_call_en = 1'b0; PC_ret_en = 1'b0; PC_ld_addr = 8'h00; PC_br_off = 8'h00;
    @(posedge PC_clk);
    #1;
    test_increment();
    test_branch();
    test_stall();
`ifdef PC_CALL_STACK_EN
    test_call_ret();
    test_stack_limits();
    test_back_to_back();
`else
    test_no_stack();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Holds the 8-bit instruction address of the 16-bit processor and drives the memory address register's input bus (PC_out → MAR_in). Each cycle it increments, loads an absolute jump target, applies a signed relative branch, or performs a subroutine call/return through a small internal return-address stack. All state is registered, and every update happens on the clock edge.

## Interface
Parameters:
- RESET_VECTOR, 8'h00, PC value after reset
- STACK_DEPTH, 4, return-stack entries; legal values 2, 4, 8

Ports:
- PC_clk  in  1  clock, rising edge
- PC_rst  in  1  synchronous, active-high reset
- PC_stall  in  1  hold all state this cycle
- PC_inc_en  in  1  PC ← PC+1
- PC_ld_en  in  1  PC ← PC_ld_addr
- PC_ld_addr  in  8  absolute target for load and call
- PC_br_en  in  1  PC ← PC + sext(PC_br_off)
- PC_br_off  in  8  two's-complement branch offset
- PC_call_en  in  1  push PC+1, then PC ← PC_ld_addr
- PC_ret_en  in  1  PC ← pop
- PC_out  out  8  current PC (registered)
- PC_sp  out  4  stack entries in use, 0..STACK_DEPTH
- PC_stack_full  out  1  PC_sp == STACK_DEPTH (combinational from PC_sp)
- PC_stack_empty  out  1  PC_sp == 0 (combinational from PC_sp)
- PC_err  out  1  sticky overflow/underflow flag

Clock/reset are fixed: one clock, PC_clk; reset PC_rst, synchronous, active-high.

## Operation
- Each cycle, exactly one action is taken, chosen by fixed priority: PC_rst > PC_stall > PC_ret_en > PC_call_en > PC_ld_en > PC_br_en > PC_inc_en > hold.
- Lower-priority requests asserted in the same cycle are dropped; they are not queued.
- Reset: PC_out=RESET_VECTOR, PC_sp=0, PC_err=0. Stack RAM contents are not cleared; they are don't-care.
- Increment: (PC+1) mod 256. 8'hFF wraps to 8'h00 with no error.
- Branch: (PC + {sign-extended PC_br_off}) mod 256, relative to the current PC_out. Example: PC=8'h02 with offset 8'hFC gives 8'hFE.
- Call when not full: stack[PC_sp] ← (PC+1) mod 256, PC_sp+1, PC ← PC_ld_addr.
- Call when full: no push; PC and PC_sp unchanged; PC_err ← 1.
- Return when not empty: PC ← stack[PC_sp-1], PC_sp-1.
- Return when empty: PC and PC_sp unchanged; PC_err ← 1.
- PC_err stays set until PC_rst; no other input clears it.
- Stall freezes PC, PC_sp, stack and PC_err, whatever else is asserted.

## Timing
- All updates take effect at the PC_clk rising edge. PC_out shows the new value in the cycle after the request (latency 1).
- Back-to-back requests in consecutive cycles are supported. Call followed immediately by ret returns to the pushed address.
- Reset asserted mid-sequence (e.g. in the same cycle as a call) wins. No push occurs, and the next cycle shows the reset values.
- PC_stack_full, PC_stack_empty and PC_sp change in the same cycle as PC_out.
- To present the new PC_out as an address, the control unit pulses MAR_wr_en one cycle after the PC update.

## Configuration
- Macro: PC_CALL_STACK_EN.
- Defined: the return stack, PC_sp, full/empty and PC_err behave as described above.
- Undefined:
  - No stack storage is built.
  - PC_call_en behaves exactly as PC_ld_en (jump, no push).
  - PC_ret_en is treated as hold and sets no error.
  - PC_sp=0, PC_stack_full=0, PC_stack_empty=1 and PC_err=0 are all constant.
- Priority order is otherwise unchanged.

## Test plan
- Reset, then 3 cycles of PC_inc_en → PC_out 00, 01, 02, 03. Load 8'hFF, then inc → 8'h00, PC_err stays 0.
- PC=8'h10: branch 8'h05 → 8'h15; branch 8'hF0 → 8'h05. Branch and inc in the same cycle → branch only.
- PC=8'h20: call 8'h80 → PC=80, sp=1; call 8'hA0 → PC=A0, sp=2; ret → 81; ret → 21, sp=0, empty=1.
- Four calls fill the stack (full=1). A fifth call leaves PC and sp unchanged and sets err=1. A ret afterwards still pops correctly. A ret on an empty stack sets err, and err clears only on PC_rst.
- Stall held with inc, ld and call asserted → PC, sp and err frozen. PC_rst in the same cycle as call → PC=RESET_VECTOR, sp=0.
- With PC_CALL_STACK_EN undefined: call 8'h40 → PC=40, sp=0. Ret → PC holds at 40, err=0.
